// File: rtl/rv_pkg.sv
// Shared defaults for the RV64 general-purpose register file.
package rv_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int REG_SEL_DEF = 5;
    localparam int NR_REG_DEF  = 1 << REG_SEL_DEF;

    // Index of the hardwired-zero register x0.
    localparam logic [REG_SEL_DEF-1:0] ZERO_REG = '0;

    localparam logic [XLEN_DEF-1:0] RESET_VAL_DEF = '0;

endpackage

// File: rtl/rv_gpr_file_if.sv
// Write/read port bundle of the register file; the slave side is the register file itself.
interface rv_gpr_file_if
    import rv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_SEL = REG_SEL_DEF,
    parameter int NR_REG  = NR_REG_DEF
);

    logic               wen;
    logic [REG_SEL-1:0] waddr;
    logic [XLEN-1:0]    wdata;
    logic [REG_SEL-1:0] raddr1;
    logic [XLEN-1:0]    rdata1;
    logic [REG_SEL-1:0] raddr2;
    logic [XLEN-1:0]    rdata2;
    logic [NR_REG-1:0]  wen_vec;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wen_vec
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wen_vec
    );

endinterface

// File: rtl/key_lookup_mux.sv
// Generic key/value lookup: returns the data of the entry whose key matches, else the default.
module key_lookup_mux #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
)(
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] i_table,
    input  logic [KEY_LEN-1:0]                   i_key,
    input  logic [DATA_LEN-1:0]                  i_default,
    output logic [DATA_LEN-1:0]                  o_data
);

    localparam int ENTRY_W = KEY_LEN + DATA_LEN;

    // Each entry is packed as {key, data}; scanning downwards lets the lowest matching entry win.
    always_comb begin
        o_data = i_default;
        for (int k = NR_KEY - 1; k >= 0; k--) begin
            if (i_table[k*ENTRY_W + DATA_LEN +: KEY_LEN] == i_key) begin
                o_data = i_table[k*ENTRY_W +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/rv_gpr_file.sv
// RV64 integer register file: two combinational read ports, one synchronous write port, x0 tied to zero.
// Optional write-first forwarding on the read ports is enabled by defining RF_BYPASS_EN.
module rv_gpr_file
    import rv_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              NR_REG    = NR_REG_DEF,
    parameter int              REG_SEL   = REG_SEL_DEF,
    parameter logic [XLEN-1:0] RESET_VAL = XLEN'(RESET_VAL_DEF)
)(
    input  logic         clk,
    input  logic         rst,
    rv_gpr_file_if.slave bus
);

    localparam int                 ENTRY_W  = REG_SEL + NR_REG;
    localparam logic [REG_SEL-1:0] ZERO_IDX = REG_SEL'(ZERO_REG);

    logic [NR_REG*ENTRY_W-1:0] w_lut;
    logic [NR_REG-1:0]         w_dec;
    logic [NR_REG-1:0]         w_wen_vec;
    logic [XLEN-1:0]           w_regs [NR_REG];
    logic [XLEN-1:0]           w_rd1;
    logic [XLEN-1:0]           w_rd2;

    // Decode table: key i -> one-hot (1<<i); x0 maps to no enable at all.
    for (genvar gi = 0; gi < NR_REG; gi++) begin : g_lut
        localparam logic [REG_SEL-1:0] KEY = REG_SEL'(gi);
        localparam logic [NR_REG-1:0]  HOT = (KEY == ZERO_IDX) ? '0 : (NR_REG'(1) << gi);
        assign w_lut[gi*ENTRY_W +: ENTRY_W] = {KEY, HOT};
    end

    key_lookup_mux #(
        .NR_KEY   (NR_REG),
        .KEY_LEN  (REG_SEL),
        .DATA_LEN (NR_REG)
    ) u_wdec (
        .i_table   (w_lut),
        .i_key     (bus.waddr),
        .i_default ('0),
        .o_data    (w_dec)
    );

    assign w_wen_vec   = bus.wen ? w_dec : '0;
    assign bus.wen_vec = w_wen_vec;

    // x0 has no storage, so it reads zero whatever RESET_VAL is.
    for (genvar gi = 0; gi < NR_REG; gi++) begin : g_reg
        if (gi == int'(ZERO_REG)) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_cell
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= RESET_VAL;
                end else if (w_wen_vec[gi]) begin
                    r_q <= bus.wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    always_comb begin
        w_rd1 = w_regs[bus.raddr1];
        w_rd2 = w_regs[bus.raddr2];
`ifdef RF_BYPASS_EN
        // Write-first: a same-cycle write to the addressed register is forwarded.
        if (bus.wen && (bus.waddr != ZERO_IDX) && (bus.raddr1 == bus.waddr)) begin
            w_rd1 = bus.wdata;
        end
        if (bus.wen && (bus.waddr != ZERO_IDX) && (bus.raddr2 == bus.waddr)) begin
            w_rd2 = bus.wdata;
        end
`endif
    end

    assign bus.rdata1 = w_rd1;
    assign bus.rdata2 = w_rd2;

endmodule

// File: tb/tb_rv_gpr_file.sv
// Self-checking bench for rv_gpr_file: directed table, reset corners, sweep and random traffic vs. an array model.
module tb_rv_gpr_file;
    import rv_pkg::*;

    localparam int XL = 64;
    localparam int RS = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rv_gpr_file_if #(.XLEN(XL), .REG_SEL(RS), .NR_REG(NR)) bus ();

    rv_gpr_file #(
        .XLEN      (XL),
        .NR_REG    (NR),
        .REG_SEL   (RS),
        .RESET_VAL ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    logic [63:0] model [NR];

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [31:0] exp_vec;
        logic [63:0] pre1;
        logic [63:0] pre2;
        logic [63:0] post1;
        logic [63:0] post2;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference read: stored value, x0 always zero, optional forwarding of the pending write.
    function automatic logic [63:0] ref_rd(input logic [4:0] ra);
        logic [63:0] v;
        v = (ra == 5'd0) ? 64'd0 : model[ra];
`ifdef RF_BYPASS_EN
        if (bus.wen && bus.waddr != 5'd0 && bus.waddr == ra) v = bus.wdata;
`endif
        return v;
    endfunction

    function automatic logic [31:0] ref_vec();
        return (bus.wen && bus.waddr != 5'd0) ? (32'd1 << bus.waddr) : 32'd0;
    endfunction

    task automatic drive(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.wen    = w;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.raddr1 = r1;
        bus.raddr2 = r2;
    endtask

    task automatic check_ports(input string tag);
        chk({tag, "_rd1"}, bus.rdata1, ref_rd(bus.raddr1));
        chk({tag, "_rd2"}, bus.rdata2, ref_rd(bus.raddr2));
        chk({tag, "_vec"}, 64'(bus.wen_vec), 64'(ref_vec()));
    endtask

    task automatic commit();
        @(posedge clk);
        if (!rst && bus.wen && bus.waddr != 5'd0) model[bus.waddr] = bus.wdata;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = 64'd0;
    endtask

    initial begin
        logic [63:0] e1, e2;

        tbl[0] = '{1'b1, 5'd3,  64'h1234_5678_9ABC_DEF0, 5'd3,  5'd0,  32'h0000_0008,
                   64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0};
        tbl[1] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd3,  32'h0000_0000,
                   64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0};
        tbl[2] = '{1'b0, 5'd7,  64'h55,                  5'd7,  5'd7,  32'h0000_0000,
                   64'd0, 64'd0, 64'd0, 64'd0};
        tbl[3] = '{1'b1, 5'd31, 64'hAA,                  5'd31, 5'd31, 32'h8000_0000,
                   64'd0, 64'd0, 64'hAA, 64'hAA};
        tbl[4] = '{1'b1, 5'd31, 64'hBB,                  5'd31, 5'd31, 32'h8000_0000,
                   64'hAA, 64'hAA, 64'hBB, 64'hBB};

        clear_model();
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd31);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd1", bus.rdata1, 64'd0);
        chk("reset_rd2", bus.rdata2, 64'd0);
        chk("reset_vec", 64'(bus.wen_vec), 64'd0);

        // Write attempted while rst is held must not land; it lands once rst is low at an edge.
        drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9);
        commit();
        chk("rst_wr_ignored", bus.rdata1, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_ports("rst_release_pre");
        commit();
        bus.wen = 1'b0;
        #1;
        chk("rst_release_post", bus.rdata1, 64'h99);

        // Asynchronous reset mid-cycle, no clock edge in between.
        @(negedge clk);
        drive(1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd9);
        commit();
        bus.wen = 1'b0;
        chk("x5_written", bus.rdata1, 64'hDEAD);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x5", bus.rdata1, 64'd0);
        chk("async_rst_x9", bus.rdata2, 64'd0);
        chk("async_rst_vec", 64'(bus.wen_vec), 64'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            drive(tbl[t].wen, tbl[t].waddr, tbl[t].wdata, tbl[t].raddr1, tbl[t].raddr2);
            #1;
            e1 = tbl[t].pre1;
            e2 = tbl[t].pre2;
`ifdef RF_BYPASS_EN
            if (tbl[t].wen && tbl[t].waddr != 5'd0 && tbl[t].raddr1 == tbl[t].waddr) e1 = tbl[t].wdata;
            if (tbl[t].wen && tbl[t].waddr != 5'd0 && tbl[t].raddr2 == tbl[t].waddr) e2 = tbl[t].wdata;
`endif
            chk($sformatf("tbl%0d_vec", t), 64'(bus.wen_vec), 64'(tbl[t].exp_vec));
            chk($sformatf("tbl%0d_pre1", t), bus.rdata1, e1);
            chk($sformatf("tbl%0d_pre2", t), bus.rdata2, e2);
            commit();
            bus.wen = 1'b0;
            #1;
            chk($sformatf("tbl%0d_post1", t), bus.rdata1, tbl[t].post1);
            chk($sformatf("tbl%0d_post2", t), bus.rdata2, tbl[t].post2);
        end

        for (int i = 1; i < NR; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 64'(i * 17), 5'(i), 5'(i));
            #1;
            chk($sformatf("sweep%0d_vec", i), 64'(bus.wen_vec), 64'(32'd1 << i));
            commit();
            bus.wen = 1'b0;
            #1;
            chk($sformatf("sweep%0d_rd1", i), bus.rdata1, 64'(i * 17));
            chk($sformatf("sweep%0d_rd2", i), bus.rdata2, 64'(i * 17));
        end

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (n % 7 == 0) bus.raddr1 = bus.waddr;
            if (n % 11 == 0) bus.raddr2 = bus.waddr;
            #1;
            check_ports($sformatf("rnd%0d", n));
            commit();
        end

        @(negedge clk);
        bus.wen = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.raddr1 = 5'(i);
            bus.raddr2 = 5'(NR - 1 - i);
            #1;
            chk($sformatf("final_x%0d", i), bus.rdata1, ref_rd(5'(i)));
            chk($sformatf("final_x%0d_p2", NR - 1 - i), bus.rdata2, ref_rd(5'(NR - 1 - i)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
